// File: rtl/ecg_bit_packer.sv
// Packs variable-length ECG beats (code field + sign bits) MSB-first into fixed W-bit words.
// A beat marked last triggers a zero-padded flush of whatever remains.
module ecg_bit_packer #(
  parameter int W      = 32,
  parameter int CODE_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] code_bits,
  input  logic [4:0]        code_len,
  input  logic [3:0]        sign_bits,
  input  logic [2:0]        size_sign_bits,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic [5:0]        out_nbits,
  output logic              out_last
);

  localparam int BEAT_W = CODE_W + 4;
  localparam int FILL_W = $clog2(2*W + 1);

  localparam logic [4:0]        CODE_MAX = 5'(CODE_W);
  localparam logic [FILL_W-1:0] W_F      = FILL_W'(W);
  localparam logic [FILL_W-1:0] TWO_W_F  = FILL_W'(2*W);
  localparam logic [FILL_W-1:0] RDY_MAX  = FILL_W'(2*W - BEAT_W);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t            state, state_next;
  logic [2*W-1:0]    acc, acc_next;
  logic [FILL_W-1:0] fill, fill_next;

  logic [4:0]        clen;
  logic [2:0]        slen;
  logic [CODE_W-1:0] code_m;
  logic [3:0]        sign_m;
  logic [BEAT_W-1:0] beat_val;
  logic [FILL_W-1:0] beat_len;
  logic              in_fire, out_fire;

  // Beat assembly: clamp lengths, drop bits above the lengths, right-align code then signs.
  always_comb begin
    clen = (code_len > CODE_MAX) ? CODE_MAX : code_len;
    slen = (size_sign_bits > 3'd4) ? 3'd4 : size_sign_bits;
    for (int i = 0; i < CODE_W; i++) code_m[i] = code_bits[i] && (5'(i) < clen);
    for (int i = 0; i < 4; i++)      sign_m[i] = sign_bits[i] && (3'(i) < slen);
    beat_val = ({4'b0, code_m} << slen) | {{CODE_W{1'b0}}, sign_m};
    beat_len = FILL_W'(clen) + FILL_W'(slen);
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      acc   <= '0;
      fill  <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      fill  <= fill_next;
    end
  end

  // NOTE: every comb output gets a default up front so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    logic [2*W-1:0]    acc_s;
    logic [FILL_W-1:0] fill_s;
    logic [FILL_W-1:0] sh;
    state_next = state;
    acc_next   = acc;
    fill_next  = fill;
    acc_s      = out_fire ? (acc << W) : acc;
    fill_s     = out_fire ? (fill - W_F) : fill;
    sh         = TWO_W_F - fill_s - beat_len;
    unique case (state)
      RUN: begin
        acc_next  = acc_s;
        fill_next = fill_s;
        if (in_fire) begin
          // The beat lands directly below the pending bits, after any shift this cycle.
          acc_next  = acc_s | ({{(2*W-BEAT_W){1'b0}}, beat_val} << sh);
          fill_next = fill_s + beat_len;
          if (in_last) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (out_fire) begin
          if (out_last) begin
            acc_next   = '0;
            fill_next  = '0;
            state_next = RUN;
          end else begin
            acc_next  = acc_s;
            fill_next = fill_s;
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs depend on registered state only, so out_ready never reaches in_ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = acc[2*W-1 -: W];
    out_nbits = '0;
    out_last  = 1'b0;
    unique case (state)
      RUN: begin
        in_ready  = (fill <= RDY_MAX);
        out_valid = (fill >= W_F);
        out_nbits = out_valid ? 6'(W) : 6'd0;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (fill <= W_F);
        out_nbits = out_last ? 6'(fill) : 6'(W);
      end
      default: ;
    endcase
  end

endmodule
